// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 16;
  localparam int unsigned PC_IDX_DEF   = 15;
  localparam int unsigned ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus the read-hazard stall flag.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned PC_IDX   = PC_IDX_DEF,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                re,
  input  logic [ADDR_W-1:0]   rm,
  input  logic [ADDR_W-1:0]   rn,
  input  logic                we_RF,
  input  logic [ADDR_W-1:0]   rd,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic                stall
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                hz_a;
  logic                hz_b;

  // Completing write clears first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (we_RF) begin
      busy_d[rd] = 1'b0;
    end
    if (issue_en && (issue_rd != PC_ADDR)) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A register being written this cycle is satisfied by the bypass, not a hazard.
  always_comb begin
    stall = 1'b0;
    hz_a  = busy_q[rm] && !(we_RF && (rd == rm));
    hz_b  = busy_q[rn] && !(we_RF && (rd == rn));
    if (!rst && re) begin
      stall = hz_a || hz_b;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_pipe.sv
// Two-read/one-write register file with registered reads, write-first bypass,
// a PC alias register and a pending-write scoreboard.
module regfile_pipe
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned PC_IDX   = PC_IDX_DEF,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             re,
  input  logic [ADDR_W-1:0]                rm,
  input  logic [ADDR_W-1:0]                rn,
  input  logic                             we_RF,
  input  logic [ADDR_W-1:0]                rd,
  input  logic [DATA_W-1:0]                WD3,
  input  logic                             issue_en,
  input  logic [ADDR_W-1:0]                issue_rd,
  input  logic [DATA_W-1:0]                pc_in,
  output logic [DATA_W-1:0]                RD1,
  output logic [DATA_W-1:0]                RD2,
  output logic                             stall,
  output logic [NUM_REGS-1:0]              busy,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  registerBank
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [NUM_REGS-1:0][DATA_W-1:0] reg_q;
  logic [DATA_W-1:0]               rd1_nxt;
  logic [DATA_W-1:0]               rd2_nxt;
  logic                            wr_ok;

  // The PC slot is never written, so it stays at its reset value of zero.
  assign wr_ok = we_RF && (rd != PC_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q <= '0;
    end else if (wr_ok) begin
      reg_q[rd] <= WD3;
    end
  end

  // PC alias takes priority, then the same-cycle write, then the array.
  assign rd1_nxt = (rm == PC_ADDR)          ? pc_in :
                   (we_RF && (rd == rm))    ? WD3   : reg_q[rm];
  assign rd2_nxt = (rn == PC_ADDR)          ? pc_in :
                   (we_RF && (rd == rn))    ? WD3   : reg_q[rn];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RD1 <= '0;
      RD2 <= '0;
    end else if (re) begin
      RD1 <= rd1_nxt;
      RD2 <= rd2_nxt;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .PC_IDX   (PC_IDX)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .re       (re),
    .rm       (rm),
    .rn       (rn),
    .we_RF    (we_RF),
    .rd       (rd),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .busy     (busy),
    .stall    (stall)
  );

  assign registerBank = reg_q;

endmodule

// File: tb/tb_regfile_pipe.sv
// Bench for regfile_pipe: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an array-based model.
module tb_regfile_pipe;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 re;
  logic [3:0]           rm;
  logic [3:0]           rn;
  logic                 we_RF;
  logic [3:0]           rd;
  logic [31:0]          WD3;
  logic                 issue_en;
  logic [3:0]           issue_rd;
  logic [31:0]          pc_in;
  logic [31:0]          RD1;
  logic [31:0]          RD2;
  logic                 stall;
  logic [15:0]          busy;
  logic [15:0][31:0]    registerBank;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  // Reference model state
  logic [31:0] m_reg [16];
  logic [31:0] m_rd1;
  logic [31:0] m_rd2;
  bit          m_busy [16];

  regfile_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .re           (re),
    .rm           (rm),
    .rn           (rn),
    .we_RF        (we_RF),
    .rd           (rd),
    .WD3          (WD3),
    .issue_en     (issue_en),
    .issue_rd     (issue_rd),
    .pc_in        (pc_in),
    .RD1          (RD1),
    .RD2          (RD2),
    .stall        (stall),
    .busy         (busy),
    .registerBank (registerBank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    if (a == 4'd15) return pc_in;
    if (we_RF && rd == a) return WD3;
    return m_reg[a];
  endfunction

  function automatic logic [15:0] model_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [511:0] model_bank();
    logic [15:0][31:0] b;
    for (int i = 0; i < 16; i++) b[i] = (i == 15) ? 32'h0 : m_reg[i];
    return 512'(b);
  endfunction

  function automatic logic model_stall();
    logic ha, hb;
    ha = m_busy[rm] && !(we_RF && rd == rm);
    hb = m_busy[rn] && !(we_RF && rd == rn);
    return !rst && re && (ha || hb);
  endfunction

  // Model advances on the same edges as the DUT, using the inputs seen there.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
      m_rd1 = 32'h0;
      m_rd2 = 32'h0;
    end else begin
      if (re) begin
        m_rd1 = model_read(rm);
        m_rd2 = model_read(rn);
      end
      if (we_RF && rd != 4'd15) m_reg[rd] = WD3;
      if (we_RF) m_busy[rd] = 1'b0;
      if (issue_en && issue_rd != 4'd15) m_busy[issue_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("rd1", 512'(RD1), 512'(m_rd1));
      chk("rd2", 512'(RD2), 512'(m_rd2));
      chk("busy", 512'(busy), 512'(model_busy_vec()));
      chk("stall", 512'(stall), 512'(model_stall()));
      chk("bank", 512'(registerBank), model_bank());
    end
  end

  task automatic idle_inputs();
    re = 1'b0; rm = 4'd0; rn = 4'd0;
    we_RF = 1'b0; rd = 4'd0; WD3 = 32'h0;
    issue_en = 1'b0; issue_rd = 4'd0; pc_in = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) return 4'd15;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1'b1;
    idle_inputs();
    re = 1'b1; rm = 4'd3; rn = 4'd7;
    repeat (3) tick();
    cmp_on = 1'b1;
    chk("reset_rd1", 512'(RD1), 512'(32'h0));
    chk("reset_busy", 512'(busy), 512'(16'h0));
    chk("reset_stall", 512'(stall), 512'(1'b0));
    rst = 1'b0;
    idle_inputs();

    // Write then read
    we_RF = 1'b1; rd = 4'd3; WD3 = 32'hDEADBEEF;
    tick();
    idle_inputs();
    re = 1'b1; rm = 4'd3; rn = 4'd0;
    tick();
    chk("wr_rd_rd1", 512'(RD1), 512'(32'hDEADBEEF));
    chk("wr_rd_rd2", 512'(RD2), 512'(32'h0));

    // Same-cycle bypass on both ports
    idle_inputs();
    we_RF = 1'b1; rd = 4'd5; WD3 = 32'h1234; re = 1'b1; rm = 4'd5; rn = 4'd5;
    tick();
    chk("bypass_rd1", 512'(RD1), 512'(32'h1234));
    chk("bypass_rd2", 512'(RD2), 512'(32'h1234));
    chk("bypass_bank5", 512'(registerBank[5]), 512'(32'h1234));

    // re=0 holds previous read data
    idle_inputs();
    rm = 4'd3; rn = 4'd3;
    tick();
    chk("hold_rd1", 512'(RD1), 512'(32'h1234));

    // PC handling
    idle_inputs();
    we_RF = 1'b1; rd = 4'd15; WD3 = 32'hFFFF;
    tick();
    chk("pc_bank15", 512'(registerBank[15]), 512'(32'h0));
    idle_inputs();
    re = 1'b1; rm = 4'd15; rn = 4'd3; pc_in = 32'h100;
    tick();
    chk("pc_rd1", 512'(RD1), 512'(32'h100));
    chk("pc_rd2", 512'(RD2), 512'(32'hDEADBEEF));

    // Scoreboard issue, hazard, completion
    idle_inputs();
    issue_en = 1'b1; issue_rd = 4'd7;
    tick();
    chk("sb_busy7_set", 512'(busy), 512'(16'h0080));
    idle_inputs();
    re = 1'b1; rm = 4'd7; rn = 4'd0;
    #1;
    chk("sb_stall_on", 512'(stall), 512'(1'b1));
    we_RF = 1'b1; rd = 4'd7; WD3 = 32'h77;
    #1;
    chk("sb_stall_off", 512'(stall), 512'(1'b0));
    tick();
    chk("sb_busy7_clr", 512'(busy), 512'(16'h0));
    chk("sb_rd1", 512'(RD1), 512'(32'h77));

    // Issue PC index never marks busy
    idle_inputs();
    issue_en = 1'b1; issue_rd = 4'd15;
    tick();
    chk("sb_pc_never_busy", 512'(busy), 512'(16'h0));

    // Issue and write to the same register: issue wins
    idle_inputs();
    issue_en = 1'b1; issue_rd = 4'd2; we_RF = 1'b1; rd = 4'd2; WD3 = 32'h22;
    tick();
    chk("sim_busy2", 512'(busy), 512'(16'h0004));
    idle_inputs();

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 512'(busy), 512'(16'h0));
    chk("arst_rd1", 512'(RD1), 512'(32'h0));
    chk("arst_rd2", 512'(RD2), 512'(32'h0));
    chk("arst_bank", 512'(registerBank), 512'(0));
    we_RF = 1'b1; rd = 4'd1; WD3 = 32'h55; issue_en = 1'b1; issue_rd = 4'd1; re = 1'b1; rm = 4'd2;
    tick();
    chk("arst_ignored_bank1", 512'(registerBank[1]), 512'(32'h0));
    chk("arst_ignored_busy", 512'(busy), 512'(16'h0));
    rst = 1'b0;
    idle_inputs();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      re       = ($urandom_range(0, 3) != 0);
      rm       = rand_addr();
      rn       = rand_addr();
      we_RF    = ($urandom_range(0, 1) == 1);
      rd       = rand_addr();
      WD3      = $urandom;
      issue_en = ($urandom_range(0, 2) == 0);
      issue_rd = rand_addr();
      pc_in    = $urandom;
      if (n % 500 == 250) rst = 1'b1;
      else rst = 1'b0;
      tick();
    end

    idle_inputs();
    rst = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_pipe.md
REGFILE_PIPE -- requirements
Module: regfile_pipe

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32: register width in bits.
REQ-002 The block SHALL take parameter NUM_REGS, default 16: register count, power of two, at least 4.
REQ-003 The block SHALL take parameter PC_IDX, default 15: index whose reads return pc_in.
REQ-004 The block SHALL derive ADDR_W = $clog2(NUM_REGS) as a localparam.
REQ-005 The block SHALL have these ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- re  in  1  read enable.
- rm, rn  in  ADDR_W  read addresses, port A and port B.
- we_RF  in  1  write enable.
- rd  in  ADDR_W  write address.
- WD3  in  DATA_W  write data.
- issue_en  in  1  marks issue_rd as pending-write.
- issue_rd  in  ADDR_W  destination being issued.
- pc_in  in  DATA_W  value returned for PC_IDX reads.
- RD1, RD2  out  DATA_W  registered read data for rm and rn.
- stall  out  1  combinational hazard flag.
- busy  out  NUM_REGS  scoreboard bits.
- registerBank  out  NUM_REGS x DATA_W  debug view of the array.

Function
REQ-006 The array SHALL update on the rising edge when we_RF=1 and rd!=PC_IDX; writes to PC_IDX SHALL be dropped.
REQ-007 When re=1, RD1/RD2 SHALL load on the rising edge, giving 1-cycle read latency; when re=0 they SHALL hold.
REQ-008 Reads of PC_IDX SHALL load pc_in.
REQ-009 When we_RF=1 and rd equals a read address (not PC_IDX) in the same cycle, that port SHALL load WD3 (write-first bypass).
REQ-010 A write that completes SHALL clear busy[rd] at the same edge; issue_en=1 SHALL set busy[issue_rd].
REQ-011 If issue and write target the same register in one cycle, busy SHALL end set (issue wins).
REQ-012 busy[PC_IDX] SHALL never be set.
REQ-013 stall SHALL be 1 iff re=1 and (busy[rm] or busy[rn]), excluding any address equal to rd while we_RF=1 that cycle.
REQ-014 The block SHALL not suppress re internally when stall=1; the caller is responsible for holding.
REQ-015 registerBank SHALL reflect array contents after each edge; entry PC_IDX SHALL read 0.

Reset
REQ-016 rst=1 SHALL asynchronously clear all array entries, RD1, RD2 and busy to 0.
REQ-017 With rst=1, stall SHALL be 0.
REQ-018 While rst=1, writes, issues and reads SHALL be ignored; normal operation SHALL start on the first rising edge after rst falls.

Structure
REQ-019 Package regfile_pkg SHALL hold the default DATA_W, NUM_REGS and PC_IDX constants and typedefs reg_addr_t and reg_data_t.
REQ-020 The scoreboard (busy vector plus stall logic) SHALL be the sub-module regfile_scoreboard; the array and read ports SHALL be in the top module.

Verification
REQ-021 Write then read: write R3=0xDEADBEEF; next cycle rm=3, re=1 -> RD1=0xDEADBEEF one edge later.
REQ-022 Bypass: same cycle we_RF=1, rd=5, WD3=0x1234, rm=5, rn=5 -> RD1=RD2=0x1234 after the edge.
REQ-023 PC handling: write R15=0xFFFF; then read rm=15 with pc_in=0x100 -> RD1=0x100; registerBank[15]=0.
REQ-024 Scoreboard: issue R7; next cycle rm=7, re=1 -> stall=1; we_RF=1, rd=7 -> stall=0 and busy[7]=0 after the edge.
REQ-025 Simultaneous events: issue_rd=2 and write rd=2 in the same cycle -> busy[2]=1.
REQ-026 Reset mid-operation: assert rst between edges with busy!=0 and RD1!=0 -> busy, RD1, RD2 and the array are 0 immediately, before the next clock edge.
